parking_occupancy_ctrl: RTL and testbench
=========================================

// Module: parking_occupancy_ctrl
// PURPOSE
//  Parametrised multi-lane occupancy counter for the car-park controller. Counts cars
//  entering/leaving through N_LANES entry and N_LANES exit sensors, grants or rejects
//  each event against CAPACITY, and drives empty/full/almost-full/hold status.
//  Sits between the gate sensor front-end and the display/barrier logic.
// PARAMETERS
//  CAPACITY   7  max cars held (>=1)
//  N_LANES    2  entry lanes = exit lanes (1..4)
//  AF_LEVEL   6  almost-full threshold (af=1 when count>=AF_LEVEL); 0<AF_LEVEL<=CAPACITY
//  LEVEL_IN   0  0: req inputs are 1-cycle pulses; 1: req inputs are levels, rising edge = event
//  CW         $clog2(CAPACITY+1)  count width (derived, not overridden)
// PORTS
//  clk      in   1        rising-edge clock
//  rst_n    in   1        async active-low reset
//  clr      in   1        sync clear: count->0, flags to reset values, err cleared
//  ent_req  in   N_LANES  entry events, bit i = lane i
//  ext_req  in   N_LANES  exit events, bit i = lane i
//  ent_ack  out  N_LANES  registered 1-cycle pulse: entry i accepted (barrier opens)
//  ent_nak  out  N_LANES  registered 1-cycle pulse: entry i rejected (lot full)
//  ext_ack  out  N_LANES  registered pulse: exit i accepted
//  ext_nak  out  N_LANES  registered pulse: exit i rejected (no car to leave)
//  count    out  CW       current occupancy
//  ef       out  1        count==0
//  ff       out  1        count==CAPACITY
//  af       out  1        count>=AF_LEVEL
//  hold     out  1        previous cycle had >=1 event and count did not change
//  err      out  1        sticky: any nak since reset/clr
// BEHAVIOUR
//  - Reset (rst_n=0, async): count=0, ef=1, ff=0, af=0, hold=0, err=0, all ack/nak=0,
//    edge-detect history=0. Mid-operation reset discards in-flight events.
//  - Event per lane: LEVEL_IN=0 -> req bit high at clk edge; LEVEL_IN=1 -> req high now and
//    low last cycle. Level held high = one event only.
//  - Per cycle, with C = count before the edge:
//    1) exits first: accept up to C exit events, lowest lane index first; rest nak.
//    2) free = CAPACITY - (C - exits_acc); accept up to free entries, lowest index first; rest nak.
//    3) count <= C - exits_acc + ents_acc. Never wraps; never exceeds CAPACITY.
//  - Same-cycle entry and exit: exit frees a slot usable by entry in that cycle
//    (full lot, 1 exit + 1 entry -> both ack, count stays CAPACITY, hold=1).
//  - Latency: ack/nak, count, ef/ff/af, hold all update on the edge that samples the event;
//    ack/nak high exactly one cycle.
//  - hold=1 iff the sampled cycle had >=1 event and count unchanged (incl. all-nak, net-zero).
//  - err set on any nak bit; cleared only by clr or rst_n. clr has priority over events that
//    cycle: events dropped, no ack/nak, count=0.
//  - Flags are decoded from the next-count value and registered; never combinational off inputs.
//  - No FSM beyond counter; edge detectors are per-lane 1-bit history regs.
// STRUCTURE
//  - parking_pkg: CAPACITY/N_LANES defaults, function cw_f(cap) = $clog2(cap+1),
//    function grant_lowest(req, n) -> first n set bits of req.
//  - Sub-module lane_edge_detect (one per req bit, 2*N_LANES instances): passes pulse through
//    when LEVEL_IN=0, rising-edge detect when LEVEL_IN=1; async reset clears history.
//  - Top: grant logic (combinational, via package function), count/flag/ack/err registers.
// TESTING
//  1. rst_n low then high, no reqs -> count=0, ef=1, ff=0, af=0, err=0, all acks 0.
//  2. CAP=7: 7 single entries on lane0 -> count 7, ff=1, af=1 after 6th; 8th entry -> ent_nak[0]=1, err=1, hold=1.
//  3. Count=6, ent_req=2'b11 same cycle -> ent_ack=2'b01, ent_nak=2'b10, count=7, ff=1.
//  4. Count=7, ext_req=2'b01 + ent_req=2'b01 same cycle -> both ack, count=7, hold=1; count=0, ext_req=2'b11 -> ext_nak=2'b11, ef=1.
//  5. LEVEL_IN=1, ent_req[0] held high 5 cycles -> exactly one ent_ack pulse, count +1.
//  6. Count=4, rst_n low mid-cycle with reqs active -> outputs reset immediately; clr with reqs -> count=0, err=0, no ack/nak.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared defaults and grant helpers for the car-park occupancy controller.
package parking_pkg;

  localparam int CAPACITY_DEF = 7;
  localparam int N_LANES_DEF  = 2;
  localparam int AF_LEVEL_DEF = 6;
  localparam int MAX_LANES    = 4;

  function automatic int cw_f(input int cap);
    return $clog2(cap + 1);
  endfunction

  // Grants the first n set bits of req, starting from lane 0.
  function automatic logic [MAX_LANES-1:0] grant_lowest(input logic [MAX_LANES-1:0] req,
                                                        input int n);
    logic [MAX_LANES-1:0] g;
    int granted;
    g       = '0;
    granted = 0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (req[i] && granted < n) begin
        g[i]    = 1'b1;
        granted = granted + 1;
      end
    end
    return g;
  endfunction

  function automatic int count_ones(input logic [MAX_LANES-1:0] v);
    int c;
    c = 0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (v[i]) c = c + 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/lane_edge_detect.sv
// Per-lane event qualifier: pulse pass-through or rising-edge detect on a level input.
module lane_edge_detect #(
  parameter bit LEVEL_IN = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic evt
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= req;
  end

  assign evt = LEVEL_IN ? (req & ~prev) : req;

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Multi-lane occupancy counter: grants entry/exit events against capacity and
// drives registered ack/nak pulses plus empty/full/almost-full/hold/err status.
module parking_occupancy_ctrl
  import parking_pkg::*;
#(
  parameter  int CAPACITY = CAPACITY_DEF,
  parameter  int N_LANES  = N_LANES_DEF,
  parameter  int AF_LEVEL = AF_LEVEL_DEF,
  parameter  int LEVEL_IN = 0,
  localparam int CW       = cw_f(CAPACITY)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [N_LANES-1:0] ent_req,
  input  logic [N_LANES-1:0] ext_req,
  output logic [N_LANES-1:0] ent_ack,
  output logic [N_LANES-1:0] ent_nak,
  output logic [N_LANES-1:0] ext_ack,
  output logic [N_LANES-1:0] ext_nak,
  output logic [CW-1:0]      count,
  output logic               ef,
  output logic               ff,
  output logic               af,
  output logic               hold,
  output logic               err
);

  logic [N_LANES-1:0]   ent_evt, ext_evt;
  logic [MAX_LANES-1:0] ent_pad, ext_pad, ent_g, ext_g, ent_n, ext_n;
  logic [CW-1:0]        next_count;
  logic                 any_evt;
  int                   cur, n_ext, n_ent, free_slots;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    lane_edge_detect #(.LEVEL_IN(LEVEL_IN != 0)) u_ent (
      .clk(clk), .rst_n(rst_n), .req(ent_req[i]), .evt(ent_evt[i])
    );
    lane_edge_detect #(.LEVEL_IN(LEVEL_IN != 0)) u_ext (
      .clk(clk), .rst_n(rst_n), .req(ext_req[i]), .evt(ext_evt[i])
    );
  end

  // Exits are granted first so a departing car frees a slot for an entry in the same cycle.
  always_comb begin
    ent_pad                = '0;
    ext_pad                = '0;
    ent_pad[N_LANES-1:0]   = ent_evt;
    ext_pad[N_LANES-1:0]   = ext_evt;
    cur                    = int'(count);
    ext_g                  = grant_lowest(ext_pad, cur);
    n_ext                  = count_ones(ext_g);
    free_slots             = CAPACITY - (cur - n_ext);
    ent_g                  = grant_lowest(ent_pad, free_slots);
    n_ent                  = count_ones(ent_g);
    ent_n                  = ent_pad & ~ent_g;
    ext_n                  = ext_pad & ~ext_g;
    next_count             = CW'(cur - n_ext + n_ent);
    any_evt                = (|ent_evt) | (|ext_evt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      ef      <= 1'b1;
      ff      <= 1'b0;
      af      <= 1'b0;
      hold    <= 1'b0;
      err     <= 1'b0;
      ent_ack <= '0;
      ent_nak <= '0;
      ext_ack <= '0;
      ext_nak <= '0;
    end else if (clr) begin
      count   <= '0;
      ef      <= 1'b1;
      ff      <= 1'b0;
      af      <= 1'b0;
      hold    <= 1'b0;
      err     <= 1'b0;
      ent_ack <= '0;
      ent_nak <= '0;
      ext_ack <= '0;
      ext_nak <= '0;
    end else begin
      count   <= next_count;
      ef      <= (next_count == '0);
      ff      <= (next_count == CW'(CAPACITY));
      af      <= (next_count >= CW'(AF_LEVEL));
      hold    <= any_evt && (next_count == count);
      err     <= err | (|ent_n) | (|ext_n);
      ent_ack <= ent_g[N_LANES-1:0];
      ent_nak <= ent_n[N_LANES-1:0];
      ext_ack <= ext_g[N_LANES-1:0];
      ext_nak <= ext_n[N_LANES-1:0];
    end
  end

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Directed self-checking bench for parking_occupancy_ctrl (pulse and level input variants).
module tb_parking_occupancy_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] ent_req = '0, ext_req = '0;
  logic [1:0] ent_ack, ent_nak, ext_ack, ext_nak;
  logic [2:0] count;
  logic       ef, ff, af, hold, err;

  logic [1:0] lent_req = '0;
  logic [1:0] lext_req = '0;
  logic [1:0] lent_ack, lent_nak, lext_ack, lext_nak;
  logic [2:0] lcount;
  logic       lef, lff, laf, lhold, lerr;

  int n_chk = 0;
  int n_fail = 0;
  int pulses;

  always #5 clk = ~clk;

  parking_occupancy_ctrl #(.CAPACITY(7), .N_LANES(2), .AF_LEVEL(6), .LEVEL_IN(0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ent_req(ent_req), .ext_req(ext_req),
    .ent_ack(ent_ack), .ent_nak(ent_nak), .ext_ack(ext_ack), .ext_nak(ext_nak),
    .count(count), .ef(ef), .ff(ff), .af(af), .hold(hold), .err(err)
  );

  parking_occupancy_ctrl #(.CAPACITY(7), .N_LANES(2), .AF_LEVEL(6), .LEVEL_IN(1)) dut_lvl (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ent_req(lent_req), .ext_req(lext_req),
    .ent_ack(lent_ack), .ent_nak(lent_nak), .ext_ack(lext_ack), .ext_nak(lext_nak),
    .count(lcount), .ef(lef), .ff(lff), .af(laf), .hold(lhold), .err(lerr)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of requests, then sample 1 time unit after the edge.
  task automatic cyc(input logic [1:0] e, input logic [1:0] x, input logic c);
    ent_req = e;
    ext_req = x;
    clr     = c;
    @(posedge clk);
    #1;
    ent_req = '0;
    ext_req = '0;
    clr     = 1'b0;
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_ef", 32'(ef), 1);
    check_eq("rst_ff", 32'(ff), 0);
    check_eq("rst_af", 32'(af), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_hold", 32'(hold), 0);
    check_eq("rst_acks", 32'({ent_ack, ent_nak, ext_ack, ext_nak}), 0);

    for (int i = 1; i <= 7; i++) begin
      cyc(2'b01, 2'b00, 1'b0);
      check_eq($sformatf("fill_count_%0d", i), 32'(count), 32'(i));
      check_eq($sformatf("fill_ack_%0d", i), 32'(ent_ack), 32'b01);
      check_eq($sformatf("fill_af_%0d", i), 32'(af), (i >= 6) ? 1 : 0);
      check_eq($sformatf("fill_ff_%0d", i), 32'(ff), (i == 7) ? 1 : 0);
      check_eq($sformatf("fill_ef_%0d", i), 32'(ef), 0);
    end
    cyc(2'b01, 2'b00, 1'b0);
    check_eq("over_nak", 32'(ent_nak), 32'b01);
    check_eq("over_ack", 32'(ent_ack), 0);
    check_eq("over_err", 32'(err), 1);
    check_eq("over_hold", 32'(hold), 1);
    check_eq("over_count", 32'(count), 7);
    cyc(2'b00, 2'b00, 1'b0);
    check_eq("idle_nak_pulse", 32'(ent_nak), 0);
    check_eq("idle_hold", 32'(hold), 0);
    check_eq("idle_err_sticky", 32'(err), 1);

    cyc(2'b01, 2'b01, 1'b0);
    check_eq("swap_ent_ack", 32'(ent_ack), 32'b01);
    check_eq("swap_ext_ack", 32'(ext_ack), 32'b01);
    check_eq("swap_count", 32'(count), 7);
    check_eq("swap_hold", 32'(hold), 1);

    cyc(2'b00, 2'b01, 1'b0);
    check_eq("exit_count", 32'(count), 6);
    check_eq("exit_ff", 32'(ff), 0);
    check_eq("exit_af", 32'(af), 1);
    cyc(2'b11, 2'b00, 1'b0);
    check_eq("dual_ent_ack", 32'(ent_ack), 32'b01);
    check_eq("dual_ent_nak", 32'(ent_nak), 32'b10);
    check_eq("dual_count", 32'(count), 7);
    check_eq("dual_ff", 32'(ff), 1);

    cyc(2'b11, 2'b11, 1'b1);
    check_eq("clr_count", 32'(count), 0);
    check_eq("clr_err", 32'(err), 0);
    check_eq("clr_ef", 32'(ef), 1);
    check_eq("clr_acks", 32'({ent_ack, ent_nak, ext_ack, ext_nak}), 0);

    cyc(2'b00, 2'b11, 1'b0);
    check_eq("empty_ext_nak", 32'(ext_nak), 32'b11);
    check_eq("empty_ext_ack", 32'(ext_ack), 0);
    check_eq("empty_ef", 32'(ef), 1);
    check_eq("empty_hold", 32'(hold), 1);
    check_eq("empty_err", 32'(err), 1);

    cyc(2'b10, 2'b00, 1'b0);
    check_eq("lane1_ack", 32'(ent_ack), 32'b10);
    cyc(2'b00, 2'b11, 1'b0);
    check_eq("one_car_ext_ack", 32'(ext_ack), 32'b01);
    check_eq("one_car_ext_nak", 32'(ext_nak), 32'b10);
    check_eq("one_car_count", 32'(count), 0);

    cyc(2'b11, 2'b00, 1'b0);
    cyc(2'b11, 2'b00, 1'b0);
    check_eq("four_count", 32'(count), 4);
    check_eq("four_af", 32'(af), 0);
    ent_req = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_count", 32'(count), 0);
    check_eq("async_rst_ef", 32'(ef), 1);
    check_eq("async_rst_ack", 32'(ent_ack), 0);
    @(posedge clk); #1;
    check_eq("held_rst_count", 32'(count), 0);
    ent_req = '0;
    rst_n   = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_count", 32'(count), 0);

    pulses = 0;
    lent_req = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (lent_ack[0]) pulses++;
    end
    check_eq("lvl_pulses", 32'(pulses), 1);
    check_eq("lvl_count", 32'(lcount), 1);
    lent_req = 2'b00;
    @(posedge clk); #1;
    lent_req = 2'b01;
    @(posedge clk); #1;
    check_eq("lvl_reedge_ack", 32'(lent_ack), 32'b01);
    check_eq("lvl_reedge_count", 32'(lcount), 2);
    lent_req = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
